// File: rtl/bus_pkg.sv
// Shared types and defaults for the read-bus master-side sequencer.
package bus_pkg;

    // Default width of the shared read-bus address.
    localparam int AW_DEFAULT = 8;

    // Address carried on the shared bus at the default width.
    typedef logic [AW_DEFAULT-1:0] bus_addr_t;

    // Sequencer states; explicit 3-bit encoding keeps the register layout stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_DATA    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

endpackage

// File: rtl/bus_read_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic            valid,
    output logic [SW-1:0]   sel
);

    logic [SW-1:0] idx;

    // Scan offsets from the far end back toward ptr so the nearest set bit wins.
    always_comb begin
        valid = |req;
        sel   = ptr;
        idx   = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = SW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/bus_read_arbiter.sv
// Master-side read-bus sequencer: round-robin arbitration, four-phase Den
// handshake with a bounded wait, and per-master done/err pulses.
module bus_read_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = AW_DEFAULT,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr_in,
    input  logic              bus_den,
    output logic [NREQ-1:0]   gnt,
    output logic              bus_rd,
    output logic [AW-1:0]     bus_addr,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err
);

    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [SW-1:0] SEL_LAST = SW'(NREQ - 1);

    state_t            state_q;
    logic [SW-1:0]     ptr_q;
    logic [SW-1:0]     sel_q;
    logic [CW-1:0]     cnt_q;
    logic [NREQ-1:0]   gnt_q;
    logic              bus_rd_q;
    logic [AW-1:0]     bus_addr_q;
    logic [NREQ-1:0]   done_q;
    logic [NREQ-1:0]   err_q;

    logic              pick_valid;
    logic [SW-1:0]     pick_sel;
    logic [AW-1:0]     addr_arr [NREQ];
    logic [CW-1:0]     cnt_inc;
    logic [SW-1:0]     ptr_d;

    // Unpack the flat address bus into one entry per master.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
            assign addr_arr[gi] = addr_in[gi*AW +: AW];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // Wait counter saturates rather than wrapping; pointer moves past the last winner.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign ptr_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

    function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    // Transaction sequencer; every output is produced from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q    <= '0;
                    gnt_q    <= '0;
                    bus_rd_q <= 1'b0;
                    if (pick_valid) begin
                        sel_q      <= pick_sel;
                        bus_addr_q <= addr_arr[pick_sel];
                        gnt_q      <= onehot(pick_sel);
                        bus_rd_q   <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_inc;
                    if (bus_den) begin
                        done_q  <= onehot(sel_q);
                        state_q <= ST_DATA;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q    <= onehot(sel_q);
                        gnt_q    <= '0;
                        bus_rd_q <= 1'b0;
                        state_q  <= ST_ERR;
                    end
                end
                ST_DATA: begin
                    cnt_q    <= '0;
                    gnt_q    <= '0;
                    bus_rd_q <= 1'b0;
                    state_q  <= ST_RELEASE;
                end
                ST_ERR: begin
                    cnt_q   <= '0;
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // A slave stuck high on Den is abandoned after the same bound, silently.
                    if (!bus_den || cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    cnt_q    <= '0;
                    gnt_q    <= '0;
                    bus_rd_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign bus_rd   = bus_rd_q;
    assign bus_addr = bus_addr_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Directed bench for bus_read_arbiter with a 1-cycle-latency slave model.
module tb_bus_read_arbiter;
    import bus_pkg::*;

    localparam int NREQ    = 4;
    localparam int AW      = AW_DEFAULT;
    localparam int TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  addr_in = '0;
    logic                bus_den;
    logic [NREQ-1:0]     gnt;
    logic                bus_rd;
    logic [AW-1:0]       bus_addr;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic                slave_den = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    int both_pulses = 0;
    int rd_cnt;
    logic [NREQ-1:0] err_acc = '0;
    logic [NREQ-1:0] done_acc;

    bus_addr_t exp_addr [NREQ] = '{8'h3A, 8'h10, 8'h20, 8'h30};

    always #5 clk = ~clk;

    // Slaves at 0x3A/0x10/0x20/0x30: Den follows rd with one cycle of latency.
    always @(posedge clk)
        slave_den <= bus_rd && (bus_addr == 8'h3A || bus_addr == 8'h10 ||
                                bus_addr == 8'h20 || bus_addr == 8'h30);
    assign bus_den = slave_den;

    bus_read_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr_in  (addr_in),
        .bus_den  (bus_den),
        .gnt      (gnt),
        .bus_rd   (bus_rd),
        .bus_addr (bus_addr),
        .done     (done),
        .err      (err)
    );

    // One line per completed or aborted transaction.
    always @(negedge clk) begin
        if (done != '0 || err != '0)
            $display("txn: addr=0x%02h done=%b err=%b", bus_addr, done, err);
        if (done != '0) done_pulses++;
        if (err != '0) err_pulses++;
        if (done != '0 && err != '0) both_pulses++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_addr(input int i, input bus_addr_t a);
        addr_in[i*AW +: AW] = a;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) set_addr(i, exp_addr[i]);

        // Reset state
        ticks(2);
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_rd", 32'(bus_rd), 32'h0);
        check_val("rst_addr", 32'(bus_addr), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);

        // Fairness: all four request continuously, ptr starts at 0
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 1; c <= 27; c++) begin
            tick();
            err_acc |= err;
            if (c % 6 == 1) begin
                check_val($sformatf("fair_gnt_c%0d", c), 32'(gnt), 32'(1) << ((c / 6) % 4));
                check_val($sformatf("fair_addr_c%0d", c), 32'(bus_addr), 32'(exp_addr[(c / 6) % 4]));
            end
            if (c % 6 == 3)
                check_val($sformatf("fair_done_c%0d", c), 32'(done), 32'(1) << ((c / 6) % 4));
            if (c == 25) req = '0;
        end
        check_val("fair_no_err", 32'(err_acc), 32'h0);
        ticks(3);

        // Single request to 0x3A (ptr=1, master 0 is the only requester)
        req = 4'b0001;
        tick();
        check_val("single_rd_c1", 32'(bus_rd), 32'h1);
        check_val("single_gnt_c1", 32'(gnt), 32'h1);
        check_val("single_addr_c1", 32'(bus_addr), 32'h3A);
        req = '0;
        tick();
        check_val("single_done_c2", 32'(done), 32'h0);
        tick();
        check_val("single_done_c3", 32'(done), 32'h1);
        check_val("single_gnt_c3", 32'(gnt), 32'h1);
        tick();
        check_val("single_rd_c4", 32'(bus_rd), 32'h0);
        check_val("single_gnt_c4", 32'(gnt), 32'h0);
        tick();
        req = 4'b0001;      // raised during RELEASE: must wait for IDLE
        tick();
        check_val("single_idle_c6", 32'(gnt), 32'h0);
        tick();
        check_val("single_regnt_c7", 32'(gnt), 32'h1);
        req = '0;
        ticks(5);

        // Pointer wrap: grant master 2, then 0101 must go to master 0
        req = 4'b0100;
        tick();
        check_val("wrap_gnt2", 32'(gnt), 32'h4);
        req = 4'b0101;
        ticks(5);
        check_val("wrap_idle", 32'(gnt), 32'h0);
        tick();
        check_val("wrap_gnt0", 32'(gnt), 32'h1);
        check_val("wrap_addr", 32'(bus_addr), 32'h3A);
        req = '0;
        ticks(5);

        // No responder at 0xFF: 15 cycles of rd, then one err pulse
        set_addr(1, 8'hFF);
        req = 4'b0010;
        tick();
        check_val("to_gnt", 32'(gnt), 32'h2);
        req = '0;
        rd_cnt = int'(bus_rd);
        done_acc = done;
        for (int c = 2; c <= 17; c++) begin
            tick();
            rd_cnt += int'(bus_rd);
            done_acc |= done;
            if (c == 15) check_val("to_err_c15", 32'(err), 32'h0);
            if (c == 16) begin
                check_val("to_err_c16", 32'(err), 32'h2);
                check_val("to_gnt_c16", 32'(gnt), 32'h0);
            end
            if (c == 17) begin
                check_val("to_err_c17", 32'(err), 32'h0);
                req = 4'b0001;
            end
        end
        check_val("to_rd_cycles", 32'(rd_cnt), 32'd15);
        check_val("to_no_done", 32'(done_acc), 32'h0);
        tick();
        check_val("to_idle_c18", 32'(gnt), 32'h0);
        tick();
        check_val("to_next_c19", 32'(gnt), 32'h1);
        req = '0;
        ticks(5);

        // Request withdrawn right after grant
        set_addr(1, 8'h10);
        req = 4'b0010;
        tick();
        check_val("wd_gnt", 32'(gnt), 32'h2);
        req = '0;
        ticks(2);
        check_val("wd_done", 32'(done), 32'h2);
        check_val("wd_err", 32'(err), 32'h0);
        ticks(3);

        // Reset during DATA, then ptr back at 0 and normal service
        req = 4'b0100;
        tick();
        check_val("mr_gnt", 32'(gnt), 32'h4);
        req = '0;
        ticks(2);
        check_val("mr_done", 32'(done), 32'h4);
        rst = 1'b1;
        tick();
        check_val("mr_gnt_rst", 32'(gnt), 32'h0);
        check_val("mr_rd_rst", 32'(bus_rd), 32'h0);
        check_val("mr_addr_rst", 32'(bus_addr), 32'h0);
        check_val("mr_done_rst", 32'(done), 32'h0);
        check_val("mr_err_rst", 32'(err), 32'h0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check_val("mr_ptr0", 32'(gnt), 32'h1);
        req = 4'b1000;
        ticks(6);
        check_val("mr_gnt3", 32'(gnt), 32'h8);
        check_val("mr_addr3", 32'(bus_addr), 32'h30);
        req = '0;
        ticks(2);
        check_val("mr_done3", 32'(done), 32'h8);
        ticks(4);

        check_val("tot_done_pulses", 32'(done_pulses), 32'd14);
        check_val("tot_err_pulses", 32'(err_pulses), 32'd1);
        check_val("tot_both", 32'(both_pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_read_arbiter.md
# bus_read_arbiter

Master-side sequencer for the shared read bus. Arbitrates between `NREQ` requesting masters in round-robin order, drives `bus_rd`/`bus_addr` for the winner, and waits for the addressed slave controller's `Den` handshake. Completes the four-phase handshake with a bounded wait and a timeout error. Sits between the masters and the slave-side address-match controllers; `bus_den` is the OR of all slave `Den` outputs.

## Interface
- `NREQ`, 4, number of requesting masters (2..8)
- `AW`, 8, bus address width
- `TIMEOUT`, 15, maximum cycles waited for `bus_den` to rise or fall before abort (≥2)

- `clk` input 1 — single clock, all state on rising edge
- `rst` input 1 — reset, synchronous, active-high
- `req` input NREQ — per-master read request, level
- `addr_in` input NREQ*AW — master i address at bits [i*AW +: AW]
- `bus_den` input 1 — OR of slave data-enable outputs
- `gnt` output NREQ — one-hot grant, zero when idle
- `bus_rd` output 1 — shared read strobe
- `bus_addr` output AW — shared address, held for the whole transaction
- `done` output NREQ — one-cycle pulse to the granted master: bus data valid this cycle
- `err` output NREQ — one-cycle pulse to the granted master: slave never responded

## Operation
- States: IDLE, REQ, DATA, RELEASE, ERR. All outputs are registered.
- Reset: state IDLE; `gnt`=0, `bus_rd`=0, `bus_addr`=0, `done`=0, `err`=0; round-robin pointer `ptr`=0; wait counter=0.
- IDLE
  - Outputs: `bus_rd`=0, `gnt`=0.
  - If any `req` bit is set: select the first set bit searching upward from `ptr` with wrap. Latch `sel` and `bus_addr`=`addr_in[sel]`, then go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - Outputs: `bus_rd`=1, `gnt[sel]`=1; the wait counter increments each cycle.
  - If `bus_den`=1: go to DATA.
  - Else if counter == TIMEOUT-1: go to ERR.
- DATA (1 cycle)
  - Outputs: `bus_rd`=1, `gnt[sel]`=1, `done[sel]`=1.
  - Go to RELEASE; the counter clears.
- ERR (1 cycle)
  - Outputs: `err[sel]`=1, `bus_rd`=0, `gnt`=0.
  - Go to RELEASE; the counter clears.
- RELEASE
  - Outputs: `bus_rd`=0, `gnt`=0.
  - If `bus_den`=0: go to IDLE and set `ptr`=(`sel`+1) mod NREQ.
  - Else if counter == TIMEOUT-1: go to IDLE anyway, with the same `ptr` update. No second `err` is raised.
- The round-robin pointer advances only on leaving RELEASE, so a master is never granted twice in a row while another master is requesting.
- A master dropping `req` mid-transaction is ignored; the transaction runs to completion. `done`/`err` still pulse.
- `req` and `addr_in` are sampled only in IDLE. Changes during other states have no effect.
- Exactly one of `done`/`err` pulses per transaction; never both.
- `rst` asserted in any state returns the block to reset values on the next edge; no `done`/`err` is generated. This drops `bus_rd`, which returns slave controllers to their wait state.

## Timing
- Slave `Den` rises one cycle after it samples `rd` with an address match, and falls one cycle after `rd` drops.
- Nominal transaction, with `req` first seen high in IDLE at cycle 0:
  - c1–c2: REQ, `bus_rd`=1 (`bus_den` rises in c2)
  - c3: DATA, `done`=1
  - c4–c5: RELEASE (`bus_den` falls in c5)
  - c6: IDLE
- Back-to-back requests therefore take 6 cycles each.
- Timeout: with no `bus_den`, REQ lasts TIMEOUT cycles, followed by ERR for 1 cycle and RELEASE for 1 cycle.
- Counter width: $clog2(TIMEOUT); it saturates and never wraps.

## Structure
- Package `bus_pkg` holds:
  - the state enum (IDLE/REQ/DATA/RELEASE/ERR, 3-bit encoding)
  - default `AW`
  - the typedef for the bus address
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: `valid`, `sel` index.
  - Instantiated once in IDLE decode.

## Test plan
Defaults: NREQ=4, AW=8, TIMEOUT=15; slave models have 1-cycle `Den` latency.
- Single request: `req`=0001, `addr_in[0]`=0x3A, slave at 0x3A → `bus_addr`=0x3A from c1; `done`=0001 at c3; `bus_rd` low at c4; IDLE at c6.
- Fairness: `req`=1111 held constant → grant order 0,1,2,3,0 with 6-cycle spacing; no `err`.
- Pointer wrap: `ptr`=3 after granting master 2, `req`=0101 → master 0 granted next (search wraps past 3).
- No responder: `req`=0010, address 0xFF matches no slave → `bus_rd` high for 15 cycles, `err`=0010 for one cycle, `done` never set, IDLE 2 cycles later.
- Request withdrawn: master 1 drops `req` in the cycle after its grant → transaction completes and `done`=0010 still pulses.
- Reset mid-transfer: `rst` asserted in DATA → next cycle all outputs 0, `ptr`=0; following `req`=1000 is granted normally.
